if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch front end for the 5-stage pipelined CPU. It owns the PC and runs a req/ack handshake with instruction memory. Fetched words go into a 2-entry skid FIFO, and the FIFO head drives the instruction and PC+4 inputs of the IF/ID pipeline register. The block honours the hazard unit's IF stall and redirects fetch on taken branches/jumps, squashing any in-flight or buffered instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- Stall_in  input  1  IF stall from hazard unit; 1 = IF/ID does not capture this edge
- Redirect  input  1  taken branch/jump; 1-cycle pulse, may be held
- Redirect_PC  input  32  new fetch address; bits [1:0] ignored (forced 00)
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address; equals internal pc
- imem_ack  input  1  memory returns imem_rdata this cycle; only meaningful while imem_req=1
- imem_rdata  input  32  instruction word
- Instruction_out  output  32  FIFO head instruction, 0 when FIFO empty
- PCPlus4_out  output  32  FIFO head PC+4, 0 when FIFO empty
- Valid_out  output  1  FIFO non-empty

## Operation
- Internal state: pc[31:0], FIFO (2 entries of {instr, pc4}), count[1:0], FSM state.
- FSM states:
  - IDLE: reset state, req=0; next edge -> REQ.
  - REQ: req=1, addr=pc.
  - HOLD: req=0, waiting for FIFO space.
  - DRAIN: req=1, waiting to discard a squashed in-flight response.
- imem_req, once asserted, stays high with stable imem_addr until the edge with imem_ack=1. Memory may ack in the first req cycle.
- Consume: at any edge with Stall_in=0 and count>0, the head entry pops. Without this, IF/ID has already captured it.
- REQ with ack, no Redirect:
  - Push {imem_rdata, pc+4}; pc <= pc+4 (mod 2^32).
  - Next state is REQ if the count after this edge is ≤1, else HOLD.
  - Push and pop on the same edge leave count unchanged.
- REQ without ack: stay REQ.
- HOLD: -> REQ at the edge where the count after that edge is ≤1.
- Redirect, which has priority over everything, at any edge:
  - pc <= {Redirect_PC[31:2],2'b00}; FIFO flushed (count=0); no pop counted.
  - REQ without ack, or DRAIN without ack: -> DRAIN.
  - REQ with ack, or DRAIN with ack: response discarded; -> REQ.
  - IDLE or HOLD: -> REQ.
- DRAIN with ack, no Redirect: response discarded, pc unchanged; -> REQ.
- FIFO never overflows: a request starts only when count ≤1, and only one request is outstanding.
- Outputs are combinational from registered FIFO head/count only. There is no combinational path from imem_* or Stall_in to any output.

## Timing
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=IDLE, count=0.
  - imem_req=0, imem_addr=RESET_PC.
  - Instruction_out=0, PCPlus4_out=0, Valid_out=0.
- Reset asserted mid-transaction aborts it immediately. Memory must tolerate req dropping.
- After rst deasserts, with zero-wait memory:
  - Edge 1: IDLE->REQ.
  - Edge 2: first push.
  - Valid_out=1 from edge 2.
- Throughput is one instruction per cycle with zero-wait memory and no stall; count stays at 1 in steady state.
- Redirect at edge N: Valid_out=0 after edge N. The first redirected instruction appears one edge after the first post-redirect ack that is not discarded.
- Stall_in held: FIFO fills to 2, FSM parks in HOLD, outputs hold the head unchanged.

## Configuration
- IF_FETCH_PERF_EN defined:
  - Adds output Bubble_Count [31:0], reset 0.
  - Increments at each edge where Stall_in=0 and Valid_out=0, Redirect included.
  - Saturates at 32'hFFFF_FFFF.
- IF_FETCH_PERF_EN undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, zero-wait memory returning addr|32'hA000_0000, no stall -> from edge 2, one instruction per edge: PCPlus4_out=4,8,12…, Instruction_out matches address 0,4,8…
- Stall_in=1 for 5 cycles mid-stream -> FIFO fills to 2, imem_req=0 (HOLD), outputs frozen. On release, entries pop in order with no loss or duplication.
- 3-cycle-latency memory, Redirect to 32'h0000_0100 on cycle 1 of an outstanding request -> DRAIN, first ack discarded, next imem_addr=0x100, next Valid_out=1 shows PCPlus4_out=0x104.
- Redirect coincident with ack and a full FIFO; Redirect_PC=32'h0000_0203 -> FIFO flushed, response dropped, imem_addr=0x200 next cycle.
- rst pulled low while imem_req=1 and count=2 -> all outputs return to reset values immediately. After release, fetch restarts at RESET_PC.
- With IF_FETCH_PERF_EN: 4 unstalled empty cycles after reset plus 1 after a redirect -> Bubble_Count increments by exactly those counts. Force count near max -> holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: owns the PC, handshakes with instruction memory and
// buffers fetched words in a 2-entry skid FIFO. Optional feature macro: IF_FETCH_PERF_EN.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Stall_in,
   input  logic        Redirect,
   input  logic [31:0] Redirect_PC,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction_out,
   output logic [31:0] PCPlus4_out,
`ifdef IF_FETCH_PERF_EN
   output logic [31:0] Bubble_Count,
`endif
   output logic        Valid_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] instr0_r, instr1_r, instr0_s, instr1_s;
   logic [31:0] pc40_r, pc41_r, pc40_s, pc41_s;
   logic [1:0]  count_r, count_s, count_after_s;
   logic        pop_s, push_s;
   logic        redirect_lsb_unused_s;

   assign redirect_lsb_unused_s = ^Redirect_PC[1:0];

   // Pop/push qualification and the FIFO occupancy after this edge when not redirecting
   always_comb begin
      pop_s         = 1'b0;
      push_s        = 1'b0;
      count_after_s = count_r;
      pop_s         = !Stall_in && (count_r != 2'd0) && !Redirect;
      push_s        = (state_r == REQ) && imem_ack && !Redirect;
      count_after_s = count_r - {1'b0, pop_s} + {1'b0, push_s};
   end

   // FIFO entry update: head shifts on pop, new word lands in the first free slot
   always_comb begin
      instr0_s = instr0_r;
      instr1_s = instr1_r;
      pc40_s   = pc40_r;
      pc41_s   = pc41_r;
      if (push_s && (count_r == 2'd0 || pop_s)) begin
         instr0_s = imem_rdata;
         pc40_s   = pc_r + 32'd4;
      end else if (pop_s) begin
         instr0_s = instr1_r;
         pc40_s   = pc41_r;
      end else begin
         instr0_s = instr0_r;
         pc40_s   = pc40_r;
      end
      if (push_s && (count_r == 2'd1) && !pop_s) begin
         instr1_s = imem_rdata;
         pc41_s   = pc_r + 32'd4;
      end else begin
         instr1_s = instr1_r;
         pc41_s   = pc41_r;
      end
   end

   // Next-state, next-PC and occupancy; a redirect overrides everything
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      count_s = count_r;
      if (Redirect) begin
         pc_s    = {Redirect_PC[31:2], 2'b00};
         count_s = 2'd0;
         case (state_r)
            REQ, DRAIN: state_s = imem_ack ? REQ : DRAIN;
            default:    state_s = REQ;
         endcase
      end else begin
         count_s = count_after_s;
         pc_s    = push_s ? (pc_r + 32'd4) : pc_r;
         case (state_r)
            IDLE:    state_s = REQ;
            REQ:     state_s = (imem_ack && (count_after_s > 2'd1)) ? HOLD : REQ;
            HOLD:    state_s = (count_after_s <= 2'd1) ? REQ : HOLD;
            DRAIN:   state_s = imem_ack ? REQ : DRAIN;
            default: state_s = IDLE;
         endcase
      end
   end

   // State, PC and FIFO registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         pc_r     <= RESET_PC;
         count_r  <= 2'd0;
         instr0_r <= 32'h0000_0000;
         instr1_r <= 32'h0000_0000;
         pc40_r   <= 32'h0000_0000;
         pc41_r   <= 32'h0000_0000;
      end else begin
         state_r  <= state_s;
         pc_r     <= pc_s;
         count_r  <= count_s;
         instr0_r <= instr0_s;
         instr1_r <= instr1_s;
         pc40_r   <= pc40_s;
         pc41_r   <= pc41_s;
      end
   end

`ifdef IF_FETCH_PERF_EN
   logic [31:0] bubble_r;

   // Counts unstalled edges with an empty FIFO, saturating at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_r <= 32'h0000_0000;
      end else if (!Stall_in && (count_r == 2'd0) && (bubble_r != 32'hFFFF_FFFF)) begin
         bubble_r <= bubble_r + 32'd1;
      end else begin
         bubble_r <= bubble_r;
      end
   end

   assign Bubble_Count = bubble_r;
`endif

   assign imem_req        = (state_r == REQ) || (state_r == DRAIN);
   assign imem_addr       = pc_r;
   assign Valid_out       = (count_r != 2'd0);
   assign Instruction_out = Valid_out ? instr0_r : 32'h0000_0000;
   assign PCPlus4_out     = Valid_out ? pc40_r : 32'h0000_0000;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: the expected consumed stream is the sequential
// address run from the last reset/redirect target; a variable-latency memory model responds.
module tb_if_fetch_unit;
   logic        clk = 1'b0;
   logic        rst, Stall_in, Redirect, imem_ack, imem_req, Valid_out;
   logic [31:0] Redirect_PC, imem_rdata, imem_addr, Instruction_out, PCPlus4_out;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] Bubble_Count;
   logic [31:0] bub_exp = 32'd0;
`endif

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] next_push;
   int          fixed_lat = 0;
   int          mem_age   = 0;
   int          cur_lat   = 0;

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk(clk), .rst(rst), .Stall_in(Stall_in), .Redirect(Redirect), .Redirect_PC(Redirect_PC),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .Instruction_out(Instruction_out), .PCPlus4_out(PCPlus4_out),
`ifdef IF_FETCH_PERF_EN
      .Bubble_Count(Bubble_Count),
`endif
      .Valid_out(Valid_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic top_up();
      while (exp_q.size() < 8) begin
         exp_q.push_back(next_push);
         next_push = next_push + 32'd4;
      end
   endtask

   task automatic seed(input logic [31:0] a);
      exp_q.delete();
      next_push = {a[31:2], 2'b00};
      top_up();
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
      top_up();
   endtask

   // Memory model: acks after a per-request latency; also checks req/addr stability
   initial begin
      logic        prev_req = 1'b0;
      logic [31:0] prev_addr = 32'd0;
      logic        old_ack;
      forever begin
         @(posedge clk);
         #1;
         old_ack = imem_ack;
         if (rst && prev_req && !old_ack && !Redirect) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_stable", imem_addr, prev_addr);
         end
         if (!rst || !imem_req) mem_age = 0;
         else if (prev_req && !old_ack) mem_age++;
         else mem_age = 0;
         if (mem_age == 0) cur_lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
         imem_ack   = rst && imem_req && (mem_age >= cur_lat);
         imem_rdata = imem_ack ? (imem_addr | 32'hA000_0000) : $urandom;
         prev_req   = rst && imem_req;
         prev_addr  = imem_addr;
      end
   end

   // Monitor: compares the FIFO head against the scoreboard, pops on a consuming edge
   initial begin
      logic [31:0] a;
      forever begin
         @(negedge clk);
         if (rst) begin
`ifdef IF_FETCH_PERF_EN
            chk("bubble_count", Bubble_Count, bub_exp);
            if (!Stall_in && !Valid_out && bub_exp != 32'hFFFF_FFFF) bub_exp = bub_exp + 32'd1;
`endif
            if (!Valid_out) begin
               chk("empty_instr", Instruction_out, 32'd0);
               chk("empty_pc4", PCPlus4_out, 32'd0);
            end else if (!Redirect) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_underflow: got entry %h expected none", PCPlus4_out);
               end else begin
                  a = exp_q[0];
                  chk("sb_instr", Instruction_out, a | 32'hA000_0000);
                  chk("sb_pc4", PCPlus4_out, a + 32'd4);
                  if (!Stall_in) void'(exp_q.pop_front());
               end
            end
         end else begin
`ifdef IF_FETCH_PERF_EN
            bub_exp = 32'd0;
`endif
         end
      end
   end

   initial begin
      int found;
      rst = 1'b0; Stall_in = 1'b0; Redirect = 1'b0; Redirect_PC = 32'd0;
      imem_ack = 1'b0; imem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0000_0000);
      chk("rst_valid", {31'd0, Valid_out}, 32'd0);
      chk("rst_instr", Instruction_out, 32'd0);
      chk("rst_pc4", PCPlus4_out, 32'd0);
      seed(32'h0000_0000);
      @(negedge clk); #1 rst = 1'b1;
      cyc();
      chk("edge1_valid", {31'd0, Valid_out}, 32'd0);
      chk("edge1_req", {31'd0, imem_req}, 32'd1);
      cyc();
      chk("edge2_valid", {31'd0, Valid_out}, 32'd1);
      chk("edge2_pc4", PCPlus4_out, 32'd4);
      repeat (10) cyc();

      // Stall mid-stream: FIFO fills and fetch parks
      Stall_in = 1'b1;
      repeat (5) cyc();
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_valid", {31'd0, Valid_out}, 32'd1);
      Stall_in = 1'b0;
      repeat (10) cyc();

      // Redirect in the first cycle of an outstanding 3-cycle request
      fixed_lat = 3;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         cyc();
         if (imem_req && mem_age == 0 && !imem_ack) found = 1;
      end
      chk("find_req_start", found, 1);
      Redirect = 1'b1; Redirect_PC = 32'h0000_0100; seed(32'h0000_0100);
      cyc();
      Redirect = 1'b0;
      chk("drain_req", {31'd0, imem_req}, 32'd1);
      chk("drain_addr", imem_addr, 32'h0000_0100);
      chk("drain_valid", {31'd0, Valid_out}, 32'd0);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         cyc();
         if (Valid_out) found = 1;
      end
      chk("redir_valid_seen", found, 1);
      chk("redir_first_pc4", PCPlus4_out, 32'h0000_0104);
      repeat (6) cyc();

      // Redirect coincident with an ack that would fill the FIFO
      fixed_lat = 1;
      Stall_in = 1'b1;
      repeat (8) cyc();
      Stall_in = 1'b0;
      cyc();
      Stall_in = 1'b1;
      found = 0;
      for (int i = 0; i < 10 && found == 0; i++) begin
         if (imem_ack) found = 1;
         else cyc();
      end
      chk("find_ack", found, 1);
      Redirect = 1'b1; Redirect_PC = 32'h0000_0203; seed(32'h0000_0203);
      cyc();
      Redirect = 1'b0;
      Stall_in = 1'b0;
      chk("flush_valid", {31'd0, Valid_out}, 32'd0);
      chk("flush_addr", imem_addr, 32'h0000_0200);
      chk("flush_req", {31'd0, imem_req}, 32'd1);
      repeat (10) cyc();

      // Asynchronous reset in the middle of a request with a buffered entry
      fixed_lat = 3;
      Stall_in = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         cyc();
         if (imem_req && Valid_out) found = 1;
      end
      chk("find_busy", found, 1);
      #1 rst = 1'b0;
      #1;
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      chk("arst_addr", imem_addr, 32'h0000_0000);
      chk("arst_valid", {31'd0, Valid_out}, 32'd0);
      chk("arst_instr", Instruction_out, 32'd0);
      chk("arst_pc4", PCPlus4_out, 32'd0);
      fixed_lat = 0;
      Stall_in = 1'b0;
      seed(32'h0000_0000);
      @(negedge clk); #1 rst = 1'b1;
      cyc();
      cyc();
      chk("restart_pc4", PCPlus4_out, 32'd4);
      repeat (5) cyc();

      // Randomized traffic: stalls, latencies and occasionally held redirects
      fixed_lat = -1;
      for (int i = 0; i < 3000; i++) begin
         Stall_in = ($urandom_range(0, 3) == 0);
         if (Redirect && $urandom_range(0, 3) == 0) begin
            Redirect = 1'b1;
         end else if ($urandom_range(0, 24) == 0) begin
            Redirect = 1'b1;
            Redirect_PC = $urandom & 32'h0000_3FFF;
            seed(Redirect_PC);
         end else begin
            Redirect = 1'b0;
         end
         cyc();
         if (Redirect) chk("rand_redir_valid", {31'd0, Valid_out}, 32'd0);
      end
      Redirect = 1'b0;
      Stall_in = 1'b0;
      repeat (10) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
